// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction fetch unit. Keeps at most one request
// in flight to instruction memory and buffers returned instructions with
// their PCs in a small in-order FIFO for the decoder. A redirect flushes
// the FIFO and discards any stale response.
// Optional build macro IFU_PERF_EN adds perf_fetch_cnt / perf_flush_cnt.
module ifu_prefetch #(
   parameter int unsigned       ADDR_W     = 64,
   parameter int unsigned       INST_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = 64'h8000_0000,
   parameter int unsigned       DEPTH      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [INST_W-1:0] inst
`ifdef IFU_PERF_EN
   ,
   output logic [63:0]       perf_fetch_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   localparam int unsigned PW      = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic [ADDR_W-1:0] req_addr_q;
   logic              req_valid_q;
   logic              drop_q;
   // a redirect arrived while the current request was still unaccepted
   logic              pend_q;

   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]       occ_q, occ_d;
   logic [ADDR_W-1:0] head_pc_q;
   logic [INST_W-1:0] head_inst_q;

   logic              accept, push, pop;
   logic [ADDR_W-1:0] redir_pc;
   logic              unused_redir_lsb;

   assign redir_pc         = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign unused_redir_lsb = ^redirect_pc[1:0];
   assign accept = (state_q == S_REQ) && imem_req_ready;
   // a response racing a redirect is stale and never enters the FIFO
   assign push   = (state_q == S_WAIT) && imem_resp_valid && !drop_q && !redirect_valid;
   assign pop    = (occ_q != '0) && inst_ready && !redirect_valid;

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = req_addr_q;
   assign inst_valid     = (occ_q != '0);
   assign inst_pc        = head_pc_q;
   assign inst           = head_inst_q;

   // next fetch PC: redirect wins; an accept after a pending redirect keeps the target
   always_comb begin
      fpc_d = fpc_q;
      if (accept && !pend_q) fpc_d = req_addr_q + ADDR_W'(4);
      if (redirect_valid)    fpc_d = redir_pc;
   end

   // FIFO pointer / occupancy next state; redirect empties the queue
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      if (redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   occ_d = occ_q + (PW+1)'(1);
            2'b01:   occ_d = occ_q - (PW+1)'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // fetch FSM: credit-gated request issue, single outstanding, stale-drop tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         fpc_q       <= RESET_ADDR;
         req_addr_q  <= RESET_ADDR;
         req_valid_q <= 1'b0;
         drop_q      <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         fpc_q <= fpc_d;
         case (state_q)
            S_IDLE: begin
               if (occ_q < DEPTH_L) begin
                  state_q     <= S_REQ;
                  req_valid_q <= 1'b1;
                  req_addr_q  <= fpc_d;
               end
            end
            S_REQ: begin
               if (imem_req_ready) begin
                  state_q     <= S_WAIT;
                  req_valid_q <= 1'b0;
                  drop_q      <= pend_q || redirect_valid;
                  pend_q      <= 1'b0;
               end else if (redirect_valid) begin
                  pend_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  drop_q <= 1'b0;
                  if (occ_d < DEPTH_L) begin
                     state_q     <= S_REQ;
                     req_valid_q <= 1'b1;
                     req_addr_q  <= fpc_d;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (redirect_valid) begin
                  drop_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // FIFO storage; the PC stored is the address of the accepted request
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= req_addr_q;
         inst_mem_q[wr_ptr_q] <= imem_resp_data;
      end
   end

   // FIFO pointers and registered head; head holds its last value when empty
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         occ_q       <= '0;
         head_pc_q   <= '0;
         head_inst_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
         if (occ_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
               head_pc_q   <= req_addr_q;
               head_inst_q <= imem_resp_data;
            end else begin
               head_pc_q   <= pc_mem_q[rd_ptr_d];
               head_inst_q <= inst_mem_q[rd_ptr_d];
            end
         end
      end
   end

`ifdef IFU_PERF_EN
   logic [63:0] fetch_cnt_q;
   logic [31:0] flush_cnt_q;

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;

   // free-running wrap-around counters of FIFO pushes and redirect cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (push)           fetch_cnt_q <= fetch_cnt_q + 64'd1;
         if (redirect_valid) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end
`endif

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction fetch unit that sits directly upstream of the core's decoder/execute stage.
- Generates sequential fetch addresses and issues them to the instruction memory over a valid/ready request channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Accepts redirects (jump/branch targets) from execute and flushes stale fetches.

Parameters:
ADDR_W, 64, PC/address width
INST_W, 32, instruction width
RESET_ADDR, 64'h80000000, first fetch address after reset
DEPTH, 2, instruction FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset; synchronous, active-high
redirect_valid  input  1  load new fetch PC, flush buffered/in-flight instructions
redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (treated as 0)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_W  fetch address
imem_resp_valid  input  1  response valid (in order; at least 1 cycle after accept)
imem_resp_data  input  INST_W  fetched instruction
inst_valid  output  1  FIFO head valid
inst_ready  input  1  decoder consumes head
inst_pc  output  ADDR_W  PC of head instruction
inst  output  INST_W  head instruction

Behaviour:
- Reset (rst=1 at clock edge): fpc=RESET_ADDR, state=IDLE, FIFO empty, drop=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_ADDR, inst_valid=0, inst_pc=0, inst=0.
- Reset mid-operation discards everything, including any outstanding response. A response arriving in the cycle after reset release is ignored because state is IDLE.
- Only one request is outstanding at a time.
- Credit: count = FIFO occupancy (registered) + 1 if state==WAIT. A request is started only when count < DEPTH.
- States:
  - IDLE: go to REQ when count < DEPTH.
  - REQ: imem_req_valid=1 and imem_req_addr=fpc. Both stay stable until imem_req_ready=1, even across a redirect. On accept: go to WAIT, fpc+=4 (mod 2^ADDR_W).
  - WAIT: on imem_resp_valid, push {pc, data} unless drop=1. Then go to REQ if count-after-update < DEPTH, else IDLE. drop clears on that response.
  - imem_req_valid is a registered decode of state==REQ.
- Latency:
  - First request is asserted in the first cycle after rst deasserts.
  - A response in cycle N gives inst_valid in cycle N+1 (no bypass).
  - Steady state with ready=1 and 1-cycle response: one instruction every 2 cycles.
- Pushed PC is the address of the accepted request, held in an internal register.
- FIFO:
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle are allowed.
  - Push never happens when full (guaranteed by credit).
  - inst/inst_pc show the head entry; contents are don't-care-free: they hold the last value when empty.
- Redirect (redirect_valid=1), highest priority:
  - FIFO flushed next cycle; a same-cycle pop is ignored.
  - fpc <= {redirect_pc[ADDR_W-1:2],2'b00}.
  - In WAIT, or in REQ with ready=1 that cycle: drop=1, so the outstanding response is discarded.
  - In REQ with ready=0: the request stays pending at its old address, and drop is set when it is accepted.
  - A response arriving in the same cycle as a redirect is discarded.
  - Next useful request uses the redirected fpc.
  - Back-to-back redirects: the last one wins.
- Address wrap: fpc=0xFFFF_FFFF_FFFF_FFFC with +4 wraps to 0.

Optional Feature:
IFU_PERF_EN
- Defined: adds output ports perf_fetch_cnt (64) and perf_flush_cnt (32), both reset to 0.
  - perf_fetch_cnt increments on each FIFO push.
  - perf_flush_cnt increments on each redirect_valid cycle.
  - Both wrap on overflow.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response -> first request addr 0x80000000 in cycle 1; inst_valid with inst_pc 0x80000000 two cycles after accept; next PCs 0x80000004, 0x80000008.
- inst_ready=0, DEPTH=2 -> exactly 2 entries buffered and no further request (imem_req_valid=0). Raising inst_ready resumes fetching at 0x80000008.
- Redirect to 0x80001002 while in WAIT -> that response is dropped, FIFO is flushed, next request addr is 0x80001000, and the next inst_pc is 0x80001000.
- Redirect while in REQ with imem_req_ready=0 for 3 cycles -> addr stays stable at the old value until accept, its response is dropped, and the following request is at the redirect target.
- rst asserted while in WAIT with 1 FIFO entry, response arriving the cycle after rst falls -> response ignored, inst_valid=0, fresh request at 0x80000000.
- IFU_PERF_EN defined, 5 instructions fetched and 2 redirects issued -> perf_fetch_cnt=5 (drops excluded), perf_flush_cnt=2.
